ex_muldiv: RTL and testbench

- Iterative RV32M multiply/divide unit that sits beside the combinational execute stage. It is launched by the decode/execute control when an M-extension instruction is issued.
- While it computes, it stalls the PC and front end through hold_o. On completion it hands a result and destination register to the register-file write-back path.
- It is parametrised in data width and generalises the single-cycle execute path to multi-cycle operations with a start/done handshake and flush support.

---
 rtl/ex_muldiv.sv | 231 +++++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
//==============================================================================
// Module      : ex_muldiv
// Description : Iterative RV32M multiply/divide unit beside the execute stage.
//               Shift-add multiply (2*DATA_W-bit product) and restoring
//               shift-subtract divide, one bit per cycle, with a start/done
//               handshake, PC hold request and flush support.
// Optional    : EX_MULDIV_FAST_SPECIAL_EN - divide by zero, signed overflow
//               or a zero multiply operand completes IDLE -> DONE directly.
// Ports       : clk, rst (async, active high)
//               start_i, op_i[2:0], rs1_rdata, rs2_rdata, rd_waddr, flush_i
//               busy_o, hold_o, done_o, rd_waddr_o, rd_wdata_o
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_muldiv #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_W-1:0]     rs1_rdata,
    input  logic [DATA_W-1:0]     rs2_rdata,
    input  logic [REG_ADDR_W-1:0] rd_waddr,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  hold_o,
    output logic                  done_o,
    output logic [REG_ADDR_W-1:0] rd_waddr_o,
    output logic [DATA_W-1:0]     rd_wdata_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Latched operation context
    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  neg_q;       // negate the final magnitude
    logic                  div_zero_q;
    logic                  ovf_q;
    logic [DATA_W-1:0]     dividend_q;  // raw rs1, needed by the overrides
    logic [DATA_W-1:0]     opnd_q;      // multiplicand or divisor magnitude
    logic [DATA_W-1:0]     acc_hi;      // product high half / partial remainder
    logic [DATA_W-1:0]     acc_lo;      // multiplier bits / dividend->quotient
    logic [CNT_W-1:0]      cnt;

    // Special-case result shared by the fast path and the end-of-run override.
    // A zero multiply operand falls through to 0.
    function automatic logic [DATA_W-1:0] special_result(
        input logic              is_rem,
        input logic [DATA_W-1:0] dividend,
        input logic              div_zero,
        input logic              ovf
    );
        logic [DATA_W-1:0] res;
        res = '0;
        if (div_zero)
            res = is_rem ? dividend : '1;
        else if (ovf)
            res = is_rem ? '0 : dividend;
        return res;
    endfunction

    //--------------------------------------------------------------------------
    // Issue-side decode of the incoming operands
    //--------------------------------------------------------------------------
    logic              in_signed_a, in_signed_b;
    logic              in_neg_a, in_neg_b;
    logic [DATA_W-1:0] in_abs_a, in_abs_b;
    logic              in_div_zero, in_ovf, in_mul_zero, in_special;
    logic              launch;

    always_comb begin
        in_signed_a = !(op_i == 3'b011 || op_i == 3'b101 || op_i == 3'b111);
        in_signed_b = in_signed_a && (op_i != 3'b010);
        in_neg_a    = in_signed_a && rs1_rdata[DATA_W-1];
        in_neg_b    = in_signed_b && rs2_rdata[DATA_W-1];
        in_abs_a    = in_neg_a ? (~rs1_rdata + 1'b1) : rs1_rdata;
        in_abs_b    = in_neg_b ? (~rs2_rdata + 1'b1) : rs2_rdata;
        in_div_zero = op_i[2] && (rs2_rdata == '0);
        in_ovf      = op_i[2] && in_signed_b && (rs1_rdata == MIN_NEG) &&
                      (rs2_rdata == '1);
        in_mul_zero = !op_i[2] && ((rs1_rdata == '0) || (rs2_rdata == '0));
        in_special  = in_div_zero || in_ovf || in_mul_zero;
    end

    assign launch = (state == IDLE) && start_i && !flush_i;

    //--------------------------------------------------------------------------
    // One iteration step of the shared datapath
    //--------------------------------------------------------------------------
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_trial;
    logic [DATA_W-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi, acc_lo[DATA_W-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (!op_q[2]) begin
            step_hi = mul_sum[DATA_W:1];
            step_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
        end else if (!div_trial[DATA_W]) begin
            // Trial subtraction did not borrow: keep it, quotient bit 1
            step_hi = div_trial[DATA_W-1:0];
            step_lo = {acc_lo[DATA_W-2:0], 1'b1};
        end else begin
            step_hi = div_shift[DATA_W-1:0];
            step_lo = {acc_lo[DATA_W-2:0], 1'b0};
        end
    end

    //--------------------------------------------------------------------------
    // Sign fix-up and result selection from the final step
    //--------------------------------------------------------------------------
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0]   quot_s, rem_s, final_res;

    always_comb begin
        prod_s = neg_q ? (~{step_hi, step_lo} + 1'b1) : {step_hi, step_lo};
        quot_s = neg_q ? (~step_lo + 1'b1) : step_lo;
        rem_s  = neg_q ? (~step_hi + 1'b1) : step_hi;
        if (div_zero_q || ovf_q)
            final_res = special_result(op_q[1], dividend_q, div_zero_q, ovf_q);
        else if (op_q[2])
            final_res = op_q[1] ? rem_s : quot_s;
        else if (op_q[1:0] == 2'b00)
            final_res = prod_s[DATA_W-1:0];
        else
            final_res = prod_s[2*DATA_W-1:DATA_W];
    end

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (launch) begin
`ifdef EX_MULDIV_FAST_SPECIAL_EN
                    state_next = in_special ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (flush_i)
                    state_next = IDLE;
                else if (cnt == CNT_LAST)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy_o = (state == CALC);
    assign hold_o = launch || (state == CALC);
    assign done_o = (state == DONE);

    //--------------------------------------------------------------------------
    // Datapath and output registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            rd_q       <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            dividend_q <= '0;
            opnd_q     <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            cnt        <= '0;
            rd_waddr_o <= '0;
            rd_wdata_o <= '0;
        end else if (launch) begin
            op_q       <= op_i;
            rd_q       <= rd_waddr;
            // Remainder follows the dividend; product/quotient follow the XOR
            neg_q      <= (op_i[2] && op_i[1]) ? in_neg_a : (in_neg_a ^ in_neg_b);
            div_zero_q <= in_div_zero;
            ovf_q      <= in_ovf;
            dividend_q <= rs1_rdata;
            opnd_q     <= op_i[2] ? in_abs_b : in_abs_a;
            acc_hi     <= '0;
            acc_lo     <= op_i[2] ? in_abs_a : in_abs_b;
            cnt        <= '0;
`ifdef EX_MULDIV_FAST_SPECIAL_EN
            if (in_special) begin
                rd_waddr_o <= rd_waddr;
                rd_wdata_o <= special_result(op_i[1], rs1_rdata, in_div_zero, in_ovf);
            end
`endif
        end else if (state == CALC && !flush_i) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                rd_waddr_o <= rd_q;
                rd_wdata_o <= final_res;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv.sv
//==============================================================================
// Module      : tb_ex_muldiv
// Description : Directed self-checking bench for ex_muldiv (DATA_W=32).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] rs1_rdata = '0;
    logic [31:0] rs2_rdata = '0;
    logic [4:0]  rd_waddr = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, hold_o, done_o;
    logic [4:0]  rd_waddr_o;
    logic [31:0] rd_wdata_o;

    int errors = 0;
    int checks = 0;

`ifdef EX_MULDIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif

    ex_muldiv #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs1_rdata  (rs1_rdata),
        .rs2_rdata  (rs2_rdata),
        .rd_waddr   (rd_waddr),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .hold_o     (hold_o),
        .done_o     (done_o),
        .rd_waddr_o (rd_waddr_o),
        .rd_wdata_o (rd_wdata_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it to completion.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int cyc;
        @(negedge clk);
        start_i = 1'b1; op_i = op; rs1_rdata = a; rs2_rdata = b; rd_waddr = rd;
        #1;
        check({tag, " hold_issue"}, {31'd0, hold_o}, 32'd1);
        @(posedge clk); #1;
        start_i = 1'b0;
        check({tag, " busy_c1"}, {31'd0, busy_o}, {31'd0, (exp_lat > 1)});
        check({tag, " hold_c1"}, {31'd0, hold_o}, {31'd0, (exp_lat > 1)});
        cyc = 1;
        while (!done_o && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " done"}, {31'd0, done_o}, 32'd1);
        check({tag, " wdata"}, rd_wdata_o, exp);
        check({tag, " waddr"}, {27'd0, rd_waddr_o}, {27'd0, rd});
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {31'd0, done_o}, 32'd0);
        check({tag, " wdata_hold"}, rd_wdata_o, exp);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst busy", {31'd0, busy_o}, 32'd0);
        check("rst done", {31'd0, done_o}, 32'd0);
        check("rst hold", {31'd0, hold_o}, 32'd0);
        check("rst wdata", rd_wdata_o, 32'd0);
        check("rst waddr", {27'd0, rd_waddr_o}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // start together with flush in IDLE is ignored
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'b000; rs1_rdata = 32'd2; rs2_rdata = 32'd2;
        #1;
        check("start_flush hold", {31'd0, hold_o}, 32'd0);
        @(posedge clk); #1;
        check("start_flush busy", {31'd0, busy_o}, 32'd0);
        start_i = 1'b0; flush_i = 1'b0;

        // Multiplies
        run_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd11, 32'hFFFFFFEB, 33);
        run_op("MULH",   3'b001, 32'h80000000, 32'h80000000, 5'd12, 32'h40000000, 33);
        run_op("MULHU",  3'b011, 32'h80000000, 32'h80000000, 5'd13, 32'h40000000, 33);
        run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd14, 32'hFFFFFFFF, 33);
        run_op("MUL0",   3'b000, 32'd0,        32'd5,        5'd15, 32'd0,        SPEC_LAT);

        // Divides
        run_op("DIV",    3'b100, 32'hFFFFFFF9, 32'd2,  5'd16, 32'hFFFFFFFD, 33);
        run_op("REM",    3'b110, 32'hFFFFFFF9, 32'd2,  5'd17, 32'hFFFFFFFF, 33);
        run_op("DIVU",   3'b101, 32'd100,      32'd7,  5'd18, 32'd14,       33);
        run_op("REMU",   3'b111, 32'd100,      32'd7,  5'd19, 32'd2,        33);

        // Boundary cases
        run_op("DIVU_Z", 3'b101, 32'h1234,     32'd0,        5'd20, 32'hFFFFFFFF, SPEC_LAT);
        run_op("REM_Z",  3'b110, 32'h1234,     32'd0,        5'd21, 32'h1234,     SPEC_LAT);
        run_op("DIV_NZ", 3'b100, 32'hFFFFFFF9, 32'd0,        5'd22, 32'hFFFFFFFF, SPEC_LAT);
        run_op("DIV_OV", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd23, 32'h80000000, SPEC_LAT);
        run_op("REM_OV", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'd0,        SPEC_LAT);

        // Flush at CALC cycle 10
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b000; rs1_rdata = 32'h11; rs2_rdata = 32'h22; rd_waddr = 5'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("flush busy_before", {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush busy", {31'd0, busy_o}, 32'd0);
        check("flush hold", {31'd0, hold_o}, 32'd0);
        check("flush done", {31'd0, done_o}, 32'd0);
        check("flush wdata", rd_wdata_o, 32'd0);
        check("flush waddr", {27'd0, rd_waddr_o}, 32'd0);
        run_op("MUL35", 3'b000, 32'd3, 32'd5, 5'd7, 32'd15, 33);

        // start held through CALC, then async reset at CALC cycle 20
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b101; rs1_rdata = 32'd100; rs2_rdata = 32'd7; rd_waddr = 5'd9;
        repeat (20) @(posedge clk);
        #1;
        check("busy_start_held", {31'd0, busy_o}, 32'd1);
        check("done_start_held", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        #2;
        start_i = 1'b0; rst = 1'b1;
        #1;
        check("arst busy", {31'd0, busy_o}, 32'd0);
        check("arst hold", {31'd0, hold_o}, 32'd0);
        check("arst done", {31'd0, done_o}, 32'd0);
        check("arst wdata", rd_wdata_o, 32'd0);
        check("arst waddr", {27'd0, rd_waddr_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("REMU_after_rst", 3'b111, 32'd100, 32'd7, 5'd4, 32'd2, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
